mdu_req_ctrl: RTL and testbench

MDU_REQ_CTRL -- requirements
Module: mdu_req_ctrl

---
 rtl/mdu_req_ctrl_pkg.sv | 30 +++
 rtl/mdu_req_ctrl_if.sv | 54 +++++
 rtl/mdu_req_ctrl.sv | 126 ++++++++++++
 tb/tb_mdu_req_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_req_ctrl_pkg.sv
// MDU op codes and op-class helpers.
// Shared by the request controller and the MDU.
package mdu_req_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_e;

  localparam int unsigned XLEN = 32;

  function automatic logic is_muldiv(
    input logic [2:0] op
  );
    return op inside {OP_MULT, OP_MULTU,
                      OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_mt(
    input logic [2:0] op
  );
    return op inside {OP_MTHI, OP_MTLO};
  endfunction

endpackage

// File: rtl/mdu_req_ctrl_if.sv
// Request, MDU and response signals of the MDU controller.
// slave = controller side, master = pipeline/MDU side.
interface mdu_req_ctrl_if;
  import mdu_req_ctrl_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            int_cancel;

  logic            mdu_start;
  logic [2:0]      mdu_op;
  logic [XLEN-1:0] mdu_a;
  logic [XLEN-1:0] mdu_b;
  logic            mdu_intreq;
  logic            mdu_busy;
  logic [XLEN-1:0] mdu_hi;
  logic [XLEN-1:0] mdu_lo;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_hi;
  logic [XLEN-1:0] rsp_lo;

  logic            hilo_stall;
  logic            timeout_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  int_cancel,
    output req_ready,
    output mdu_start, mdu_op, mdu_a, mdu_b,
    output mdu_intreq,
    input  mdu_busy, mdu_hi, mdu_lo,
    output rsp_valid, rsp_hi, rsp_lo,
    input  rsp_ready,
    output hilo_stall, timeout_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    output int_cancel,
    input  req_ready,
    input  mdu_start, mdu_op, mdu_a, mdu_b,
    input  mdu_intreq,
    output mdu_busy, mdu_hi, mdu_lo,
    input  rsp_valid, rsp_hi, rsp_lo,
    output rsp_ready,
    input  hilo_stall, timeout_err
  );

endinterface

// File: rtl/mdu_req_ctrl.sv
// Issues one MDU op at a time, waits for completion
// with a busy timeout, and holds the HI/LO response.
module mdu_req_ctrl #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic          clk,
  input  logic          reset,
  mdu_req_ctrl_if.slave bus
);
  import mdu_req_ctrl_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  mdu_op_e         r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_rsp_hi;
  logic [XLEN-1:0] r_rsp_lo;
  logic [TW-1:0]   r_tmo;
  logic            r_err;

  logic w_accept;
  logic w_cap;
  logic w_tmo_hit;
  logic w_issue;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_cap       = 1'b0;
    w_tmo_hit   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid &&
            (is_muldiv(bus.req_op) ||
             is_mt(bus.req_op))) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.int_cancel || is_mt(r_op))
          w_state_nxt = S_IDLE;
        else
          w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Result is valid on the first non-busy WAIT cycle.
        if (!bus.mdu_busy) begin
          w_cap       = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_tmo == TMO_LAST) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.rsp_ready)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op     <= OP_NONE;
      r_a      <= '0;
      r_b      <= '0;
      r_rsp_hi <= '0;
      r_rsp_lo <= '0;
      r_tmo    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= mdu_op_e'(bus.req_op);
        r_a  <= bus.req_a;
        r_b  <= bus.req_b;
      end
      if (r_state == S_ISSUE)
        r_tmo <= '0;
      else if (r_state == S_WAIT && bus.mdu_busy)
        r_tmo <= r_tmo + TW'(1);
      if (w_cap) begin
        r_rsp_hi <= bus.mdu_hi;
        r_rsp_lo <= bus.mdu_lo;
      end else if (w_tmo_hit) begin
        r_rsp_hi <= '0;
        r_rsp_lo <= '0;
        r_err    <= 1'b1;
      end
    end
  end

  assign w_issue = (r_state == S_ISSUE);

  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.mdu_start   = w_issue && is_muldiv(r_op);
  assign bus.mdu_op      = w_issue ? r_op : OP_NONE;
  assign bus.mdu_a       = r_a;
  assign bus.mdu_b       = r_b;
  assign bus.mdu_intreq  = w_issue && bus.int_cancel;
  assign bus.rsp_valid   = (r_state == S_DONE);
  assign bus.rsp_hi      = r_rsp_hi;
  assign bus.rsp_lo      = r_rsp_lo;
  assign bus.hilo_stall  = (r_state != S_IDLE) ||
                           bus.mdu_busy;
  assign bus.timeout_err = r_err;

endmodule

// File: tb/tb_mdu_req_ctrl.sv
// Bench for mdu_req_ctrl: behavioural MDU plus
// reference arithmetic, directed and random ops.
module tb_mdu_req_ctrl;

  localparam int TMO = 15;

  logic clk;
  logic reset;
  bit   stuck;
  int   checks;
  int   errors;
  bit   err_exp;

  logic [63:0] pend;
  int          cnt;

  mdu_req_ctrl_if bus ();

  mdu_req_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {hi, lo} of an op from plain arithmetic
  function automatic logic [63:0] ref_res(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = signed'({{32{a[31]}}, a});
    sb = signed'({{32{b[31]}}, b});
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: return sa * sb;
      3'd2: return ua * ub;
      3'd3: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: return {32'(ua % ub), 32'(ua / ub)};
      default: return 64'd0;
    endcase
  endfunction

  // MDU: mult busy 4 cycles, div busy 9 cycles
  always @(posedge clk) begin
    if (!reset) begin
      bus.mdu_busy <= 1'b0;
      bus.mdu_hi   <= '0;
      bus.mdu_lo   <= '0;
      cnt          <= 0;
    end else if (bus.mdu_busy) begin
      if (stuck)
        cnt <= 1;
      else if (cnt <= 1) begin
        bus.mdu_busy <= 1'b0;
        bus.mdu_hi   <= pend[63:32];
        bus.mdu_lo   <= pend[31:0];
      end else
        cnt <= cnt - 1;
    end else if (bus.mdu_start && !bus.mdu_intreq) begin
      bus.mdu_busy <= 1'b1;
      cnt  <= (bus.mdu_op inside {3'd1, 3'd2}) ? 4 : 9;
      pend <= ref_res(bus.mdu_op, bus.mdu_a, bus.mdu_b);
    end else if (bus.mdu_op == 3'd5)
      bus.mdu_hi <= bus.mdu_a;
    else if (bus.mdu_op == 3'd6)
      bus.mdu_lo <= bus.mdu_a;
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input bit          cancel,
    input int          hold,
    input bit          rv_acc,
    input bit          tmo
  );
    logic [63:0] exp;
    int lat;
    int want;
    bit md;
    md   = op inside {3'd1, 3'd2, 3'd3, 3'd4};
    exp  = tmo ? 64'd0 : ref_res(op, a, b);
    want = tmo ? TMO + 1 :
           (op inside {3'd1, 3'd2}) ? 6 : 11;
    tick();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(negedge clk);
    chk("idle_ready", bus.req_ready, 1);
    tick();
    bus.req_valid  = 1'b0;
    bus.int_cancel = cancel;
    @(negedge clk);
    chk("issue_op", bus.mdu_op, op);
    chk("issue_start", bus.mdu_start, md);
    chk("issue_intreq", bus.mdu_intreq, cancel);
    chk("issue_a", bus.mdu_a, a);
    chk("issue_b", bus.mdu_b, b);
    chk("issue_ready", bus.req_ready, 0);
    tick();
    bus.int_cancel = 1'b0;
    if (cancel || !md) begin
      @(negedge clk);
      chk("noresp_ready", bus.req_ready, 1);
      chk("noresp_valid", bus.rsp_valid, 0);
      chk("noresp_busy", bus.mdu_busy, 0);
      chk("noresp_start", bus.mdu_start, 0);
      return;
    end
    lat = 1;
    while (lat <= 40) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      if (lat == 1)
        chk("wait_stall", bus.hilo_stall, 1);
      tick();
      lat++;
    end
    if (tmo) err_exp = 1'b1;
    chk("latency", lat, want);
    chk("rsp_data", {bus.rsp_hi, bus.rsp_lo}, exp);
    chk("tmo_err", bus.timeout_err, err_exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      @(negedge clk);
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_data", {bus.rsp_hi, bus.rsp_lo}, exp);
      chk("hold_stall", bus.hilo_stall, 1);
      chk("hold_ready", bus.req_ready, 0);
    end
    stuck         = 1'b0;
    bus.rsp_ready = 1'b1;
    if (rv_acc) begin
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd1;
    end
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("acc_ready", bus.req_ready, 1);
    chk("acc_valid", bus.rsp_valid, 0);
    chk("acc_op", bus.mdu_op, 0);
    if (!tmo)
      chk("acc_stall", bus.hilo_stall, 0);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    err_exp        = 1'b0;
    stuck          = 1'b0;
    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.int_cancel = 1'b0;
    bus.rsp_ready  = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_data", {bus.rsp_hi, bus.rsp_lo}, 0);
    chk("rst_err", bus.timeout_err, 0);
    chk("rst_start", bus.mdu_start, 0);
    chk("rst_op", bus.mdu_op, 0);
    chk("rst_stall", bus.hilo_stall, 0);
    tick();
    reset = 1'b1;

    do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0);
    chk("mult_const", {bus.rsp_hi, bus.rsp_lo},
        64'hFFFF_FFFF_FFFF_FFFE);
    do_op(3'd4, 32'd100, 32'd7, 0, 3, 1, 0);
    chk("divu_const", {bus.rsp_hi, bus.rsp_lo},
        {32'd2, 32'd14});
    do_op(3'd5, 32'h1234_5678, 32'd0, 0, 0, 0, 0);
    chk("mfhi", bus.mdu_hi, 32'h1234_5678);
    do_op(3'd6, 32'hCAFE_0001, 32'd0, 0, 0, 0, 0);
    chk("mflo", bus.mdu_lo, 32'hCAFE_0001);
    do_op(3'd3, 32'd50, 32'd3, 1, 0, 0, 0);

    for (int k = 0; k < 2; k++) begin
      tick();
      bus.req_valid = 1'b1;
      bus.req_op    = (k == 0) ? 3'd7 : 3'd0;
      tick();
      @(negedge clk);
      chk("ignore_ready", bus.req_ready, 1);
      chk("ignore_op", bus.mdu_op, 0);
      bus.req_valid = 1'b0;
    end

    for (int n = 0; n < 16; n++) begin
      logic [2:0]  op;
      logic [31:0] b;
      op = 3'($urandom_range(1, 4));
      b  = $urandom;
      if (b == 0) b = 32'd1;
      do_op(op, $urandom, b, 0,
            $urandom_range(0, 2),
            1'($urandom_range(0, 1)), 0);
    end

    tick();
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd2;
    bus.req_a     = 32'd9;
    bus.req_b     = 32'd9;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("rstw_ready", bus.req_ready, 1);
    chk("rstw_valid", bus.rsp_valid, 0);
    chk("rstw_busy", bus.mdu_busy, 0);
    chk("rstw_stall", bus.hilo_stall, 0);
    tick();
    reset = 1'b1;

    stuck = 1'b1;
    do_op(3'd1, 32'd3, 32'd4, 0, 1, 0, 1);
    do_op(3'd2, 32'd6, 32'd7, 0, 0, 0, 0);
    chk("err_sticky", bus.timeout_err, 1);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("err_clear", bus.timeout_err, 0);
    chk("err_rsp", {bus.rsp_hi, bus.rsp_lo}, 0);
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
